// File: rtl/ula_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ULA.
package ula_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_LSL  = 3'b110;
    localparam logic [2:0] OP_LSR  = 3'b111;

    typedef enum logic [1:0] {
        ST_OCIOSO  = 2'd0,
        ST_EXECUTA = 2'd1,
        ST_DESLOCA = 2'd2
    } estado_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_LSL) || (op == OP_LSR);
    endfunction

endpackage

// File: rtl/ula_nucleo_comb.sv
// Combinational logic/arithmetic core for the single-cycle opcodes (000-101).
module ula_nucleo_comb
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] resultado_c,
    output logic             carry_c,
    output logic             overflow_c
);

    logic [WIDTH:0] soma;
    logic [WIDTH:0] dif;

    // Extra MSB holds carry out of ADD and borrow of SUB
    assign soma = {1'b0, a} + {1'b0, b};
    assign dif  = {1'b0, a} - {1'b0, b};

    always_comb begin
        resultado_c = '0;
        carry_c     = 1'b0;
        overflow_c  = 1'b0;
        case (op)
            OP_AND:  resultado_c = a & b;
            OP_OR:   resultado_c = a | b;
            OP_NOT:  resultado_c = ~a;
            OP_NAND: resultado_c = ~(a & b);
            OP_ADD: begin
                resultado_c = soma[WIDTH-1:0];
                carry_c     = soma[WIDTH];
                overflow_c  = (a[WIDTH-1] == b[WIDTH-1]) &&
                              (soma[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                resultado_c = dif[WIDTH-1:0];
                carry_c     = dif[WIDTH];
                overflow_c  = (a[WIDTH-1] != b[WIDTH-1]) &&
                              (dif[WIDTH-1] != a[WIDTH-1]);
            end
            default: resultado_c = a;
        endcase
    end

endmodule

// File: rtl/ula_seq_param.sv
// Registered ULA with start/busy/done handshake and one-bit-per-cycle shifts.
module ula_seq_param
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       seletor,
    output logic [WIDTH-1:0] resultado,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_overflow,
    output logic             flag_negativo,
    output logic             ocupado,
    output logic             pronto
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    estado_t              estado;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [2:0]           op_r;
    logic [WIDTH-1:0]     work;
    logic [SHAMT_W-1:0]   contador;
    logic                 carry_cand;

    logic [WIDTH-1:0]     nucleo_res;
    logic                 nucleo_c;
    logic                 nucleo_v;

    ula_nucleo_comb #(.WIDTH(WIDTH)) u_nucleo (
        .a           (a_r),
        .b           (b_r),
        .op          (op_r),
        .resultado_c (nucleo_res),
        .carry_c     (nucleo_c),
        .overflow_c  (nucleo_v)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado        <= ST_OCIOSO;
            a_r           <= '0;
            b_r           <= '0;
            op_r          <= OP_AND;
            work          <= '0;
            contador      <= '0;
            carry_cand    <= 1'b0;
            resultado     <= '0;
            flag_zero     <= 1'b0;
            flag_carry    <= 1'b0;
            flag_overflow <= 1'b0;
            flag_negativo <= 1'b0;
            ocupado       <= 1'b0;
            pronto        <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                ST_OCIOSO: begin
                    if (inicio) begin
                        a_r        <= A;
                        b_r        <= B;
                        op_r       <= seletor;
                        work       <= A;
                        contador   <= B[SHAMT_W-1:0];
                        carry_cand <= 1'b0;
                        ocupado    <= 1'b1;
                        estado     <= is_shift(seletor) ? ST_DESLOCA : ST_EXECUTA;
                    end
                end
                ST_EXECUTA: begin
                    resultado     <= nucleo_res;
                    flag_zero     <= (nucleo_res == '0);
                    flag_carry    <= nucleo_c;
                    flag_overflow <= nucleo_v;
                    flag_negativo <= nucleo_res[WIDTH-1];
                    pronto        <= 1'b1;
                    ocupado       <= 1'b0;
                    estado        <= ST_OCIOSO;
                end
                ST_DESLOCA: begin
                    if (contador == '0) begin
                        resultado     <= work;
                        flag_zero     <= (work == '0);
                        flag_carry    <= carry_cand;
                        flag_overflow <= 1'b0;
                        flag_negativo <= work[WIDTH-1];
                        pronto        <= 1'b1;
                        ocupado       <= 1'b0;
                        estado        <= ST_OCIOSO;
                    end else if (op_r == OP_LSL) begin
                        work       <= {work[WIDTH-2:0], 1'b0};
                        carry_cand <= work[WIDTH-1];
                        contador   <= contador - 1'b1;
                    end else begin
                        work       <= {1'b0, work[WIDTH-1:1]};
                        carry_cand <= work[0];
                        contador   <= contador - 1'b1;
                    end
                end
                default: estado <= ST_OCIOSO;
            endcase
        end
    end

endmodule

// File: doc/ula_seq_param.md
Name: ula_seq_param

Overview:
- Parametrised, registered successor of the 4-bit combinational ULA with LSL/LSR.
- Operand width is set by WIDTH, and outputs are registered.
- Adds status flags (Z/C/V/N) and a start/busy/done handshake.
- LSL/LSR become barrel-free multi-cycle shifts by a variable amount taken from B, one bit per cycle. The block is meant for a small datapath/CPU where area matters more than shift latency.

Parameters:
- WIDTH, 8, operand/result width. Must be a power of two, at least 4.
- SHAMT_W, $clog2(WIDTH), localparam. Width of the shift amount field B[SHAMT_W-1:0].

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- inicio  in  1  start request; sampled only in OCIOSO
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B; low SHAMT_W bits give the shift amount for LSL/LSR
- seletor  in  3  operation: 000 AND, 001 OR, 010 NOT A, 011 NAND, 100 ADD, 101 SUB, 110 LSL, 111 LSR
- resultado  out  WIDTH  registered result, held until the next completion
- flag_zero  out  1  resultado == 0
- flag_carry  out  1  carry/borrow/last bit shifted out
- flag_overflow  out  1  signed overflow (ADD/SUB only)
- flag_negativo  out  1  resultado[WIDTH-1]
- ocupado  out  1  operation in progress
- pronto  out  1  one-cycle pulse when resultado and flags update

Behaviour:
- Reset (async, rst=1):
  - resultado, all flags, ocupado and pronto go to 0; FSM goes to OCIOSO.
  - Any operation in flight is aborted and discarded.
- FSM states: OCIOSO, EXECUTA, DESLOCA.
- OCIOSO:
  - inicio=1 at edge k latches A, B and seletor into internal regs and sets ocupado=1.
  - Next state is DESLOCA (counter=B[SHAMT_W-1:0], work=A) for 110/111, else EXECUTA.
  - pronto=0 in this state.
- EXECUTA, edge k+1:
  - resultado and flags are written from the latched operands; pronto=1 for that cycle; ocupado=0; back to OCIOSO.
- DESLOCA, each edge:
  - If counter==0: resultado=work, flags written, pronto=1, ocupado=0, back to OCIOSO.
  - Otherwise: work shifts one bit (LSL fills LSB with 0; LSR fills MSB with 0), the bit shifted out is captured as the carry candidate, and counter decrements.
  - pronto occurs at edge k+1+n, so ocupado is high for n+1 cycles.
- Shift amount:
  - n=0 behaves like EXECUTA latency with resultado=A and C=0.
  - n ranges 0..WIDTH-1. Bits of B above SHAMT_W are ignored.
- Arithmetic (all results truncated to WIDTH):
  - ADD: C = carry out of the MSB. V = operands have the same sign and the result sign differs.
  - SUB: A - B. C=1 on borrow (A<B unsigned). V = operands have different signs and the result sign differs from A.
  - Logic ops: C=0, V=0.
  - Shifts: C = last bit shifted out, V=0.
- Flags: Z and N are derived from the new resultado on every completion.
- inicio while ocupado=1 is ignored; it is not queued.
- A, B and seletor changes during ocupado have no effect.
- Back-to-back: inicio may be high in the cycle after pronto (FSM already in OCIOSO). Throughput for non-shift ops is 1 operation per 2 cycles.
- resultado and flags are stable between pronto pulses.

Decomposition:
- Package ula_pkg holds:
  - opcode localparams OP_AND, OP_OR, OP_NOT, OP_NAND, OP_ADD, OP_SUB, OP_LSL, OP_LSR (3 bits);
  - FSM state encoding ST_OCIOSO, ST_EXECUTA, ST_DESLOCA (2 bits).
- One sub-module: ula_nucleo_comb, a purely combinational WIDTH-parametrised core for opcodes 000–101. It returns the result plus carry and overflow. The top owns the FSM, shift register, counter and output registers.

Test Plan (WIDTH=8 unless noted; k = edge sampling inicio):
- ADD A=0x7F B=0x01 -> at k+1: resultado=0x80, V=1, N=1, C=0, Z=0, pronto=1 for exactly one cycle. Then ADD 0xFF+0x01 -> 0x00, C=1, Z=1, V=0.
- SUB 0x05-0x03 -> 0x02, C=0. SUB 0x03-0x05 -> 0xFE, C=1, N=1. SUB 0x80-0x01 -> 0x7F, V=1.
- Shifts:
  - LSL A=0x81 B=0x03 -> ocupado high 4 cycles, pronto at k+4, resultado=0x08, C=0.
  - LSR A=0x81 B=0x01 -> pronto at k+2, resultado=0x40, C=1.
  - LSR A=0x5A B=0x08 (n=0) -> pronto at k+1, resultado=0x5A, C=0.
- Handshake:
  - Pulse inicio again during a 7-step LSL -> ignored; only one pronto; result unchanged by the second request.
  - Changing A mid-shift does not alter the result.
- Reset mid-operation:
  - Assert rst asynchronously (between edges) during DESLOCA -> all outputs 0 immediately, and no pronto afterwards.
  - After release, AND 0xF0&0x3C -> 0x30.
- WIDTH=4 regression:
  - A=0101 B=0011: all 8 seletor codes match the reference model; LSL gives 1000 (n=3).
  - A=1001 B=0001: LSL -> 0010, C=1; LSR -> 0100, C=1.
